// File: rtl/mem_arbiter_pkg.sv
// Shared widths and request codes for the two-port cache-to-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDRWIDTH    = 16;
  localparam int unsigned WORDWIDTH    = 16;
  localparam int unsigned IOSTATEWIDTH = 2;

  typedef enum logic [IOSTATEWIDTH-1:0] {
    IO_IDLE  = 2'b00,
    IO_READ  = 2'b01,
    IO_WRITE = 2'b10
  } io_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Code 2'b11 is deliberately not a request.
  function automatic logic is_req(input logic [IOSTATEWIDTH-1:0] rw);
    return (rw == IO_READ) || (rw == IO_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_mem_array.sv
// Backing store: synchronous write, combinational read, no reset on contents.
module mem_array
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORDWIDTH-1:0] wdata_i,
  output logic [WORDWIDTH-1:0] rdata_o
);

  logic [WORDWIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two cache ports a fixed-latency access
// to a shared memory; completion pulses are registered and appear in S_GAP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwFromCacheA,
  input  logic [ADDRWIDTH-1:0]    addrFromCacheA,
  input  logic [WORDWIDTH-1:0]    dataFromCacheA,
  output logic [WORDWIDTH-1:0]    dataToCacheA,
  output logic                    rdEnToCacheA,
  output logic                    wbDoneToCacheA,
  input  logic [IOSTATEWIDTH-1:0] rwFromCacheB,
  input  logic [ADDRWIDTH-1:0]    addrFromCacheB,
  input  logic [WORDWIDTH-1:0]    dataFromCacheB,
  output logic [WORDWIDTH-1:0]    dataToCacheB,
  output logic                    rdEnToCacheB,
  output logic                    wbDoneToCacheB
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  port_e                sel_q, sel_d;
  port_e                last_q, last_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [WORDWIDTH-1:0] wdata_q, wdata_d;
  logic [WORDWIDTH-1:0] rdA_q, rdA_d, rdB_q, rdB_d;
  logic                 rdEnA_q, rdEnA_d, rdEnB_q, rdEnB_d;
  logic                 wbA_q, wbA_d, wbB_q, wbB_d;
  logic                 reqA, reqB, mem_we;
  logic [WORDWIDTH-1:0] mem_rdata;
  logic                 unused_addr_bits;

  assign reqA = is_req(rwFromCacheA);
  assign reqB = is_req(rwFromCacheB);
  assign unused_addr_bits = ^{addrFromCacheA, addrFromCacheB};

  mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdA_d   = rdA_q;
    rdB_d   = rdB_q;
    rdEnA_d = 1'b0;
    rdEnB_d = 1'b0;
    wbA_d   = 1'b0;
    wbB_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (reqA || reqB) begin
          // Tie goes to whichever port was not served last.
          sel_d = (reqA && (!reqB || last_q == PORT_B)) ? PORT_A : PORT_B;
          if (sel_d == PORT_A) begin
            wr_d    = (rwFromCacheA == IO_WRITE);
            addr_d  = addrFromCacheA[AW-1:0];
            wdata_d = dataFromCacheA;
          end else begin
            wr_d    = (rwFromCacheB == IO_WRITE);
            addr_d  = addrFromCacheB[AW-1:0];
            wdata_d = dataFromCacheB;
          end
          cnt_d   = 4'(MEM_LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        last_d  = sel_q;
        if (wr_q) begin
          mem_we = !reset;
          wbA_d  = (sel_q == PORT_A);
          wbB_d  = (sel_q == PORT_B);
        end else if (sel_q == PORT_A) begin
          rdEnA_d = 1'b1;
          rdA_d   = mem_rdata;
        end else begin
          rdEnB_d = 1'b1;
          rdB_d   = mem_rdata;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= PORT_A;
      last_q  <= PORT_B;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdA_q   <= '0;
      rdB_q   <= '0;
      rdEnA_q <= 1'b0;
      rdEnB_q <= 1'b0;
      wbA_q   <= 1'b0;
      wbB_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdA_q   <= rdA_d;
      rdB_q   <= rdB_d;
      rdEnA_q <= rdEnA_d;
      rdEnB_q <= rdEnB_d;
      wbA_q   <= wbA_d;
      wbB_q   <= wbB_d;
    end
  end

  assign dataToCacheA   = rdA_q;
  assign dataToCacheB   = rdB_q;
  assign rdEnToCacheA   = rdEnA_q;
  assign rdEnToCacheB   = rdEnB_q;
  assign wbDoneToCacheA = wbA_q;
  assign wbDoneToCacheB = wbB_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin order, reset abort,
// address wrap and latched-request behaviour.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned LAT = 2;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rwA, rwB;
  logic [15:0] addrA, addrB, dinA, dinB, doutA, doutB;
  logic        rdEnA, wbA, rdEnB, wbB;

  mem_arbiter #(.MEM_LAT(LAT), .MEM_DEPTH(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .rwFromCacheA   (rwA),
    .addrFromCacheA (addrA),
    .dataFromCacheA (dinA),
    .dataToCacheA   (doutA),
    .rdEnToCacheA   (rdEnA),
    .wbDoneToCacheA (wbA),
    .rwFromCacheB   (rwB),
    .addrFromCacheB (addrB),
    .dataFromCacheB (dinB),
    .dataToCacheB   (doutB),
    .rdEnToCacheB   (rdEnB),
    .wbDoneToCacheB (wbB)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    bit          wr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  overlap = 0;
  int  npulse;
  int  n_tests = 0;
  int  n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every done pulse becomes an event stamped with the posedge count.
  always @(negedge clk) begin
    ev_t e;
    npulse = int'(rdEnA) + int'(wbA) + int'(rdEnB) + int'(wbB);
    if (npulse > 1) overlap++;
    e.cyc = cyc;
    if (rdEnA) begin e.port = 0; e.wr = 0; e.data = doutA; evq.push_back(e); end
    if (wbA)   begin e.port = 0; e.wr = 1; e.data = doutA; evq.push_back(e); end
    if (rdEnB) begin e.port = 1; e.wr = 0; e.data = doutB; evq.push_back(e); end
    if (wbB)   begin e.port = 1; e.wr = 1; e.data = doutB; evq.push_back(e); end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
    if (!port) begin rwA = rw; addrA = a; dinA = d; end
    else       begin rwB = rw; addrB = a; dinB = d; end
  endtask

  task automatic wait_ev(output bit got, output ev_t e);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (evq.size() > 0) begin
        e = evq.pop_front();
        got = 1;
      end else begin
        step();
      end
    end
  endtask

  // Single transaction from an idle arbiter; optionally alters the address after grant.
  task automatic xact(input string tag, input bit port, input logic [1:0] rw,
                      input logic [15:0] a, input logic [15:0] d,
                      input bit chg, input logic [15:0] a2, output ev_t e);
    int c;
    bit got;
    c = cyc;
    drive(port, rw, a, d);
    step();
    if (chg) begin
      if (!port) addrA = a2; else addrB = a2;
    end
    wait_ev(got, e);
    check_eq({tag, "_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_lat"}, e.cyc - c - 1, LAT + 1);
    check_eq({tag, "_port"}, 32'(e.port), 32'(port));
    check_eq({tag, "_kind"}, 32'(e.wr), 32'(rw == WR));
    drive(port, ID, a, d);
    step();
    check_eq({tag, "_single"}, evq.size(), 0);
  endtask

  initial begin
    ev_t e, e1, e2;
    bit  got;
    int  c;
    bit  exp_port [4];

    reset = 1'b1;
    drive(0, ID, '0, '0);
    drive(1, ID, '0, '0);
    repeat (3) step();
    check_eq("rst_rdEnA", 32'(rdEnA), 0);
    check_eq("rst_wbA", 32'(wbA), 0);
    check_eq("rst_rdEnB", 32'(rdEnB), 0);
    check_eq("rst_wbB", 32'(wbB), 0);
    check_eq("rst_doutA", 32'(doutA), 0);
    check_eq("rst_doutB", 32'(doutB), 0);
    reset = 1'b0;
    step();

    xact("wr10", 0, WR, 16'h0010, 16'hA5A5, 0, '0, e);
    xact("rd10", 0, RD, 16'h0010, 16'h0000, 0, '0, e);
    check_eq("rd10_data", 32'(e.data), 32'hA5A5);
    check_eq("rd10_hold", 32'(doutA), 32'hA5A5);

    xact("wr05", 0, WR, 16'h0005, 16'h0505, 0, '0, e);
    xact("wr06", 1, WR, 16'h0006, 16'h0606, 0, '0, e);
    xact("wr03", 0, WR, 16'h0003, 16'h5555, 0, '0, e);
    xact("wr20", 0, WR, 16'h0020, 16'h2222, 0, '0, e);
    xact("wr21", 1, WR, 16'h0021, 16'h2121, 0, '0, e);

    xact("rd110", 0, RD, 16'h0110, 16'h0000, 0, '0, e);
    check_eq("rd110_data", 32'(e.data), 32'hA5A5);

    xact("rdchg", 0, RD, 16'h0020, 16'h0000, 1, 16'h0021, e);
    check_eq("rdchg_data", 32'(e.data), 32'h2222);

    xact("rdB06", 1, RD, 16'h0006, 16'h0000, 0, '0, e);
    check_eq("rdB06_data", 32'(e.data), 32'h0606);
    check_eq("doutA_hold", 32'(doutA), 32'h2222);

    drive(0, 2'b11, 16'h0010, 16'h0000);
    repeat (6) step();
    check_eq("code11_idle", evq.size(), 0);
    drive(0, ID, '0, '0);
    step();

    // Reset one cycle after a B write is granted must abort it.
    drive(1, WR, 16'h0003, 16'h1234);
    step();
    reset = 1'b1;
    drive(1, ID, '0, '0);
    step();
    step();
    reset = 1'b0;
    repeat (6) step();
    check_eq("abort_nopulse", evq.size(), 0);
    check_eq("abort_doutB", 32'(doutB), 0);
    xact("rd03", 0, RD, 16'h0003, 16'h0000, 0, '0, e);
    check_eq("rd03_data", 32'(e.data), 32'h5555);

    // Simultaneous reads right after reset; each port drops once served.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    c = cyc;
    drive(0, RD, 16'h0005, '0);
    drive(1, RD, 16'h0006, '0);
    wait_ev(got, e1);
    drive(e1.port, ID, '0, '0);
    wait_ev(got, e2);
    drive(e2.port, ID, '0, '0);
    check_eq("tie_first", 32'(e1.port), 0);
    check_eq("tie_first_data", 32'(e1.data), 32'h0505);
    check_eq("tie_first_lat", e1.cyc - c - 1, LAT + 1);
    check_eq("tie_second", 32'(e2.port), 1);
    check_eq("tie_second_data", 32'(e2.data), 32'h0606);
    check_eq("tie_spacing", e2.cyc - e1.cyc, LAT + 3);
    repeat (3) step();
    check_eq("tie_extra", evq.size(), 0);

    // Both ports held active: strict alternation.
    exp_port = '{0, 1, 0, 1};
    drive(0, RD, 16'h0005, '0);
    drive(1, RD, 16'h0006, '0);
    for (int k = 0; k < 4; k++) begin
      wait_ev(got, e);
      check_eq($sformatf("rr%0d_port", k), 32'(e.port), 32'(exp_port[k]));
      check_eq($sformatf("rr%0d_data", k), 32'(e.data), exp_port[k] ? 32'h0606 : 32'h0505);
      if (k == 3) begin
        drive(0, ID, '0, '0);
        drive(1, ID, '0, '0);
      end else begin
        step();
      end
    end
    repeat (4) step();
    check_eq("rr_extra", evq.size(), 0);
    check_eq("no_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles from grant to done; legal range 1..15.
REQ-002 Parameter MEM_DEPTH, default 256, number of words in the backing store.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rwFromCacheA  input  `IOSTATEWIDTH  port A request code: IDLE, READ or WRITE.
REQ-006 addrFromCacheA  input  `ADDRWIDTH  port A word address.
REQ-007 dataFromCacheA  input  `WORDWIDTH  port A write data.
REQ-008 dataToCacheA  output  `WORDWIDTH  port A read data.
REQ-009 rdEnToCacheA  output  1  port A read-complete pulse.
REQ-010 wbDoneToCacheA  output  1  port A write-complete pulse.
REQ-011 rwFromCacheB, addrFromCacheB, dataFromCacheB, dataToCacheB, rdEnToCacheB, wbDoneToCacheB: the same as REQ-005..010, for port B.

Function
REQ-012 Request codes come from def.v: IDLE=2'b00, READ=2'b01, WRITE=2'b10; code 2'b11 is treated as IDLE.
REQ-013 FSM states: S_IDLE, S_BUSY, S_DONE, S_GAP.
REQ-014 S_IDLE, one port requesting: grant that port, latch its rw/addr/data, load the latency counter with MEM_LAT-1, go to S_BUSY.
REQ-015 S_IDLE, both ports requesting: grant the port that was not last served (round-robin pointer).
REQ-016 S_BUSY decrements the counter each cycle; at zero it goes to S_DONE.
REQ-017 Read latency: grant edge to done-pulse cycle is exactly MEM_LAT+1 cycles.
REQ-018 S_DONE, READ: drive mem[addr] on dataToCacheX and assert rdEnToCacheX for exactly one cycle.
REQ-019 S_DONE, WRITE: write mem[addr] at the end of the cycle and assert wbDoneToCacheX for exactly one cycle.
REQ-020 S_DONE then goes to S_GAP and toggles the round-robin pointer to the served port.
REQ-021 S_GAP lasts one cycle, lets the served cache drop rw to IDLE, then returns to S_IDLE; no new grant is issued in S_GAP.
REQ-022 dataToCacheX holds its last read value until the next read completion on that port.
REQ-023 Latched request fields are used for the whole transaction; changes on the request inputs after the grant are ignored.
REQ-024 Address bits above log2(MEM_DEPTH) are ignored (address wraps modulo MEM_DEPTH).
REQ-025 A request held across S_GAP is re-arbitrated in S_IDLE as a new request.
REQ-026 At most one done pulse is asserted per cycle across both ports; rdEn and wbDone are never asserted together.

Reset
REQ-027 Reset drives state to S_IDLE, the counter to 0 and all rdEn/wbDone outputs to 0.
REQ-028 Reset drives dataToCacheA and dataToCacheB to 0.
REQ-029 Reset sets the round-robin pointer so that port A wins the first tie.
REQ-030 Reset mid-transaction aborts it: no done pulse, and a pending write is not committed.
REQ-031 Memory contents are not cleared by reset.

Structure
REQ-032 Request codes, `ADDRWIDTH, `WORDWIDTH and `IOSTATEWIDTH live in the shared def.v; FSM state encodings stay local.
REQ-033 The backing store is a sub-module mem_array (synchronous write, combinational read, parameter MEM_DEPTH), instantiated once.

Verification
REQ-034 Port A WRITE addr 0x10 data 0xA5A5, then READ 0x10 -> wbDoneToCacheA pulses once; on the read, rdEnToCacheA pulses with dataToCacheA=0xA5A5, MEM_LAT+1 cycles after the grant.
REQ-035 A and B both READ in the same cycle after reset -> A completes first, then B, with no overlapping pulses.
REQ-036 A and B request continuously for 4 transactions -> service order is A,B,A,B.
REQ-037 B WRITE addr 0x3 data 0x1234, reset asserted 1 cycle after the grant, then A READ 0x3 -> no wbDone pulse; data is the prior memory value, not 0x1234.
REQ-038 A READ addr 0x110 with MEM_DEPTH=256 -> returns the content of addr 0x10.
REQ-039 A changes addrFromCacheA during S_BUSY -> response uses the originally latched address.
